// File: rtl/operand_fetch.sv
// Register-read stage: register file, operand select and same-cycle writeback bypass into one output register.
// Latency 1 cycle from capture to out_valid; throughput 1 per cycle while out_ready is high.
// Backpressure: in_ready = !out_valid || out_ready; while stalled the output register holds, except that writebacks update held source operands.
module operand_fetch #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          in_opcode,
    input  logic [2:0]          in_cc,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic [REG_BITS-1:0] in_ra,
    input  logic [REG_BITS-1:0] in_rb,
    input  logic                in_use_imm,
    input  logic [WIDTH-1:0]    in_imm,
    input  logic                wb_en,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic [WIDTH-1:0]    wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_opcode,
    output logic [2:0]          out_cc,
    output logic [REG_BITS-1:0] out_rd,
    output logic [WIDTH-1:0]    a_data,
    output logic [WIDTH-1:0]    b_data
);

    logic [WIDTH-1:0]    regs [NREGS];
    logic [REG_BITS-1:0] held_ra;
    logic [REG_BITS-1:0] held_rb;
    logic                held_use_imm;
    logic [WIDTH-1:0]    rd_a;
    logic [WIDTH-1:0]    rd_b;
    logic                capture;
    logic                stall;
    logic                wb_commit;

    assign in_ready  = !out_valid || out_ready;
    assign capture   = in_valid && in_ready && !flush;
    assign stall     = out_valid && !out_ready;
    assign wb_commit = wb_en && (wb_rd != '0);

    // Read ports with writeback bypass; r0 is hardwired to zero.
    always_comb begin
        rd_a = regs[in_ra];
        rd_b = regs[in_rb];
        if (wb_en && wb_rd == in_ra) rd_a = wb_data;
        if (wb_en && wb_rd == in_rb) rd_b = wb_data;
        if (in_ra == '0) rd_a = '0;
        if (in_rb == '0) rd_b = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            out_valid    <= 1'b0;
            out_opcode   <= '0;
            out_cc       <= '0;
            out_rd       <= '0;
            a_data       <= '0;
            b_data       <= '0;
            held_ra      <= '0;
            held_rb      <= '0;
            held_use_imm <= 1'b0;
        end else begin
            if (wb_commit) regs[wb_rd] <= wb_data;

            if (flush) begin
                out_valid <= 1'b0;
            end else if (capture) begin
                out_valid    <= 1'b1;
                out_opcode   <= in_opcode;
                out_cc       <= in_cc;
                out_rd       <= in_rd;
                a_data       <= rd_a;
                b_data       <= in_use_imm ? in_imm : rd_b;
                held_ra      <= in_ra;
                held_rb      <= in_rb;
                held_use_imm <= in_use_imm;
            end else if (stall) begin
                // A writeback landing while stalled must reach the held operands.
                if (wb_commit && wb_rd == held_ra) a_data <= wb_data;
                if (wb_commit && wb_rd == held_rb && !held_use_imm) b_data <= wb_data;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a register-file model predicts each captured instruction.
module tb_operand_fetch;

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  cc;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ui;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_opcode = '0;
    logic [2:0]  in_cc = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_ra = '0;
    logic [4:0]  in_rb = '0;
    logic        in_use_imm = 1'b0;
    logic [31:0] in_imm = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_opcode;
    logic [2:0]  out_cc;
    logic [4:0]  out_rd;
    logic [31:0] a_data;
    logic [31:0] b_data;

    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    item_t       sb[$];
    item_t       mon_it;
    logic [31:0] mreg [32];
    logic        m_valid = 1'b0;

    operand_fetch #(.WIDTH(32), .NREGS(32), .REG_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_cc(in_cc), .in_rd(in_rd),
        .in_ra(in_ra), .in_rb(in_rb), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_cc(out_cc), .out_rd(out_rd),
        .a_data(a_data), .b_data(b_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mrd(input logic [4:0] i);
        if (i == 0) return 32'h0;
        if (wb_en && wb_rd == i) return wb_data;
        return mreg[i];
    endfunction

    // Advance one clock, predicting the stage's behaviour from the inputs currently driven.
    task automatic tick();
        item_t it;
        logic  acc;
        logic  nv;
        nv = m_valid;
        if (!rst_n) begin
            sb.delete();
            nv = 1'b0;
        end else begin
            acc = in_valid && (!m_valid || out_ready) && !flush;
            if (m_valid && !out_ready && sb.size() > 0) begin
                if (flush) begin
                    void'(sb.pop_back());
                end else if (wb_en && wb_rd != 0) begin
                    if (sb[sb.size()-1].ra == wb_rd) sb[sb.size()-1].a = wb_data;
                    if (sb[sb.size()-1].rb == wb_rd && !sb[sb.size()-1].ui) sb[sb.size()-1].b = wb_data;
                end
            end
            if (acc) begin
                it.op = in_opcode; it.cc = in_cc; it.rd = in_rd;
                it.ra = in_ra; it.rb = in_rb; it.ui = in_use_imm;
                it.a  = mrd(in_ra);
                it.b  = in_use_imm ? in_imm : mrd(in_rb);
                sb.push_back(it);
            end
            nv = flush ? 1'b0 : acc ? 1'b1 : (m_valid && out_ready) ? 1'b0 : m_valid;
        end
        @(posedge clk);
        if (!rst_n) begin
            foreach (mreg[i]) mreg[i] = 32'h0;
        end else if (wb_en && wb_rd != 0) begin
            mreg[wb_rd] = wb_data;
        end
        m_valid = nv;
        #1;
    endtask

    task automatic set_in(input logic [4:0] op, input logic [4:0] ra, input logic [4:0] rb,
                          input logic ui, input logic [31:0] imm, input logic [4:0] rd);
        in_valid = 1'b1; in_opcode = op; in_cc = op[2:0] ^ 3'b101; in_rd = rd;
        in_ra = ra; in_rb = rb; in_use_imm = ui; in_imm = imm;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        wb_en = en; wb_rd = rd; wb_data = d;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", out_valid, m_valid);
            chk("in_ready", in_ready, !m_valid || out_ready);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    mon_it = sb.pop_front();
                    n_out++;
                    chk("opcode", out_opcode, mon_it.op);
                    chk("cc", out_cc, mon_it.cc);
                    chk("rd", out_rd, mon_it.rd);
                    chk("a_data", a_data, mon_it.a);
                    chk("b_data", b_data, mon_it.b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        // 1. reset, then read never-written registers
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_a", a_data, 0);
        chk("rst_b", b_data, 0);
        chk("rst_opcode", out_opcode, 0);
        set_in(5'd1, 5'd5, 5'd6, 1'b0, 32'h0, 5'd1); tick();
        in_valid = 1'b0; tick();

        // 2. write then immediate-form ADD
        set_wb(1'b1, 5'd3, 32'h0000_1234); tick();
        set_wb(1'b0, 5'd0, 32'h0);
        set_in(5'd2, 5'd3, 5'd0, 1'b1, 32'h10, 5'd2); tick();
        chk("t2_a", a_data, 32'h1234);
        chk("t2_b", b_data, 32'h10);
        in_valid = 1'b0; tick();

        // 3. same-cycle bypass with ra == rb
        set_wb(1'b1, 5'd7, 32'hDEAD_BEEF);
        set_in(5'd3, 5'd7, 5'd7, 1'b0, 32'h0, 5'd3); tick();
        set_wb(1'b0, 5'd0, 32'h0);
        chk("t3_a", a_data, 32'hDEAD_BEEF);
        chk("t3_b", b_data, 32'hDEAD_BEEF);
        in_valid = 1'b0; tick();

        // 4. stall: held ra=3 picks up writeback, held immediate does not
        out_ready = 1'b0;
        set_in(5'd4, 5'd3, 5'd3, 1'b1, 32'hAB, 5'd4); tick();
        in_valid = 1'b0;
        set_wb(1'b1, 5'd3, 32'h55); tick();
        set_wb(1'b0, 5'd0, 32'h0);
        chk("t4_a", a_data, 32'h55);
        chk("t4_b", b_data, 32'hAB);
        chk("t4_in_ready", in_ready, 0);
        tick();
        out_ready = 1'b1;
        set_in(5'd5, 5'd3, 5'd7, 1'b0, 32'h0, 5'd5); tick();
        chk("t4_valid_kept", out_valid, 1);
        in_valid = 1'b0; tick();

        // 5. r0 write ignored, then 8 back-to-back issues
        set_wb(1'b1, 5'd0, 32'hFFFF_FFFF); tick();
        set_wb(1'b0, 5'd0, 32'h0);
        set_in(5'd6, 5'd0, 5'd0, 1'b0, 32'h0, 5'd6); tick();
        chk("t5_r0", a_data, 0);
        in_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            set_wb(1'b1, 5'(i + 8), 32'h1000 + 32'(i) * 32'h111); tick();
        end
        set_wb(1'b0, 5'd0, 32'h0);
        tick();
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            set_in(5'(i + 8), 5'(i + 9), 5'(i + 17), 1'b0, 32'h0, 5'(i)); tick();
        end
        in_valid = 1'b0; tick();
        chk("t5_count", n_out - base, 8);

        // randomized traffic with stalls, writebacks and occasional flush
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_opcode = 5'($urandom); in_cc = 3'($urandom); in_rd = 5'($urandom);
            in_ra = 5'($urandom); in_rb = 5'($urandom);
            in_use_imm = 1'($urandom_range(0, 1)); in_imm = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            set_wb(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        set_wb(1'b0, 5'd0, 32'h0); tick();

        // 6. flush with held and incoming instruction; concurrent wb still commits
        out_ready = 1'b0;
        set_in(5'd9, 5'd1, 5'd2, 1'b0, 32'h0, 5'd9); tick();
        set_in(5'd10, 5'd2, 5'd3, 1'b0, 32'h0, 5'd10);
        flush = 1'b1;
        set_wb(1'b1, 5'd12, 32'hCAFE); tick();
        flush = 1'b0; in_valid = 1'b0;
        set_wb(1'b0, 5'd0, 32'h0);
        chk("t6_flush", out_valid, 0);
        out_ready = 1'b1;
        set_in(5'd11, 5'd12, 5'd0, 1'b0, 32'h0, 5'd11); tick();
        chk("t6_wb_kept", a_data, 32'hCAFE);
        in_valid = 1'b0; tick();

        // reset mid-stall drops the instruction and clears registers
        out_ready = 1'b0;
        set_in(5'd12, 5'd12, 5'd12, 1'b0, 32'h0, 5'd12); tick();
        in_valid = 1'b0;
        rst_n = 1'b0; tick();
        chk("t6_rst_valid", out_valid, 0);
        rst_n = 1'b1; out_ready = 1'b1;
        set_in(5'd13, 5'd12, 5'd7, 1'b0, 32'h0, 5'd13); tick();
        chk("t6_rst_regs", a_data, 0);
        in_valid = 1'b0; tick();
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
